apb_master_arbiter: RTL and testbench

- Shares the single slave port of the APB node between NB_REQ on-chip requesters, for example the core data port, the debug module and a DMA channel.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases into the node.
- Returns read data and error to the granted requester.
- Sits directly upstream of the APB node. Address decode and slave select stay in the node.

---
 rtl/apb_master_arbiter.sv | 156 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter that shares one APB slave port
// between NB_REQ requesters. It sequences the SETUP/ACCESS phases and returns
// read data and error to the granted requester.
// Optional feature macro: APB_ARB_TIMEOUT_EN. When it is defined, a transfer
// whose ACCESS phase runs for TIMEOUT_CYCLES cycles without pready_i is aborted
// and answered with an error.
//
// state  | meaning
// IDLE   | no transfer in flight; arbitrate and grant in the same cycle
// SETUP  | psel high, penable low, exactly one cycle
// ACCESS | psel and penable high until pready_i (or timeout)
module apb_master_arbiter #(
  parameter int NB_REQ         = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0]                        we_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    addr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    wdata_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic [NB_REQ-1:0]                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                rdata_o,
  output logic                                     err_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Reject parameter sets the arbiter is not built for at elaboration time
  if (NB_REQ < 2 || NB_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_arbiter: NB_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_winner;
  logic             w_found;
  logic             w_done;
  logic             w_abort;

  // Round-robin search starting just after the last winner
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] sel;
    idx      = 0;
    sel      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NB_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      sel = IDX_W'(idx);
      if (!w_found && req_i[sel]) begin
        w_found  = 1'b1;
        w_winner = sel;
      end
    end
  end

  // Grant is a combinational pulse, only while idle
  always_comb begin
    gnt_o = '0;
    if (r_state == ST_IDLE && w_found) gnt_o = NB_REQ'(1) << w_winner;
  end

  assign psel_o    = (r_state != ST_IDLE);
  assign penable_o = (r_state == ST_ACCESS);
  assign w_done    = (r_state == ST_ACCESS) && pready_i;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  // Count ACCESS cycles without pready; cleared while in SETUP so it starts at 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_ACCESS && !pready_i) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Abort on the edge where the count would reach TIMEOUT_CYCLES; pready wins a tie
  assign w_abort = (r_state == ST_ACCESS) && !pready_i &&
                   (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_abort = 1'b0;
`endif

  // FSM, request capture and completion response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= IDX_W'(NB_REQ - 1);
      r_owner  <= '0;
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_SETUP;
            r_rr_ptr <= w_winner;
            r_owner  <= w_winner;
            pwrite_o <= we_i[w_winner];
            paddr_o  <= addr_i[w_winner];
            pwdata_o <= wdata_i[w_winner];
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_state  <= ST_IDLE;
            rvalid_o <= NB_REQ'(1) << r_owner;
            rdata_o  <= pwrite_o ? '0 : prdata_i;
            err_o    <= pslverr_i;
          end else if (w_abort) begin
            r_state  <= ST_IDLE;
            rvalid_o <= NB_REQ'(1) << r_owner;
            rdata_o  <= '0;
            err_o    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_apb_master_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NB-1:0]          req_i;
  logic [NB-1:0]          we_i;
  logic [NB-1:0][AW-1:0]  addr_i;
  logic [NB-1:0][DW-1:0]  wdata_i;
  logic [NB-1:0]          gnt_o;
  logic [NB-1:0]          rvalid_o;
  logic [DW-1:0]          rdata_o;
  logic                   err_o;
  logic                   psel_o;
  logic                   penable_o;
  logic                   pwrite_o;
  logic [AW-1:0]          paddr_o;
  logic [DW-1:0]          pwdata_o;
  logic [DW-1:0]          prdata_i;
  logic                   pready_i;
  logic                   pslverr_i;

  int errors = 0;
  int checks = 0;

  apb_master_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = $urandom;
      #1;
      checks++; if ({rvalid_o, err_o, psel_o, penable_o, pwrite_o, gnt_o} !== '0) begin
        errors++; $display("FAIL reset_ctrl: got rv=%b err=%b psel=%b pen=%b pw=%b gnt=%b exp all 0",
                           rvalid_o, err_o, psel_o, penable_o, pwrite_o, gnt_o); end
      checks++; if ({rdata_o, paddr_o, pwdata_o} !== '0) begin
        errors++; $display("FAIL reset_data: got rdata=%h paddr=%h pwdata=%h exp 0",
                           rdata_o, paddr_o, pwdata_o); end
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    next_cycle(); req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 32'h1A10_0004; #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rd_gnt: got %b exp 0001", gnt_o); end
    checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL rd_psel0: got %b exp 0", psel_o); end
    next_cycle(); req_i = '0; addr_i[0] = 32'hFFFF_FFFF; #1;
    checks++; if ({psel_o, penable_o} !== 2'b10) begin errors++; $display("FAIL rd_setup: got psel/pen=%b exp 10", {psel_o, penable_o}); end
    checks++; if (paddr_o !== 32'h1A10_0004 || pwrite_o !== 1'b0) begin
      errors++; $display("FAIL rd_addr: got %h w=%b exp 1a100004 w=0", paddr_o, pwrite_o); end
    next_cycle(); pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF; #1;
    checks++; if ({psel_o, penable_o, rvalid_o} !== 6'b110000) begin
      errors++; $display("FAIL rd_access: got psel/pen/rv=%b exp 110000", {psel_o, penable_o, rvalid_o}); end
    next_cycle(); pready_i = 1'b0; prdata_i = '0; #1;
    checks++; if (rvalid_o !== 4'b0001 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
      errors++; $display("FAIL rd_resp: got rv=%b rdata=%h err=%b exp 0001 deadbeef 0", rvalid_o, rdata_o, err_o); end
    checks++; if ({psel_o, penable_o} !== 2'b00) begin errors++; $display("FAIL rd_idle: got %b exp 00", {psel_o, penable_o}); end
    next_cycle(); #1;
    checks++; if (rvalid_o !== '0 || rdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_hold: got rv=%b rdata=%h exp 0000 deadbeef", rvalid_o, rdata_o); end
  endtask

  task automatic test_write_wait();
    int pen_cnt = 0;
    do_reset();
    next_cycle(); req_i[2] = 1'b1; we_i[2] = 1'b1; wdata_i[2] = 32'h0000_00A5; addr_i[2] = $urandom; #1;
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL wr_gnt: got %b exp 0100", gnt_o); end
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); req_i = '0; wdata_i[2] = '0; pready_i = (c == 6); prdata_i = $urandom | 32'h1; #1;
      if (psel_o) begin
        checks++; if (pwdata_o !== 32'hA5 || pwrite_o !== 1'b1) begin
          errors++; $display("FAIL wr_fields c%0d: got pwdata=%h pwrite=%b exp a5 1", c, pwdata_o, pwrite_o); end
      end
      if (penable_o) pen_cnt++;
      if (c == 7) begin
        checks++; if (rvalid_o !== 4'b0100 || rdata_o !== '0) begin
          errors++; $display("FAIL wr_resp: got rv=%b rdata=%h exp 0100 0", rvalid_o, rdata_o); end
      end else begin
        checks++; if (rvalid_o !== '0) begin errors++; $display("FAIL wr_rv c%0d: got %b exp 0000", c, rvalid_o); end
      end
    end
    checks++; if (pen_cnt !== 5) begin errors++; $display("FAIL wr_penable_len: got %0d exp 5", pen_cnt); end
  endtask

  task automatic test_contention();
    logic [NB-1:0] exp_gnt;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      next_cycle(); req_i = '1; pready_i = 1'b1; prdata_i = $urandom; #1;
      exp_gnt = (c % 3 == 0) ? (NB'(1) << ((c / 3) % NB)) : '0;
      checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rr_gnt c%0d: got %b exp %b", c, gnt_o, exp_gnt); end
    end
    clear_inputs();
  endtask

  task automatic test_error();
    logic [DW-1:0] d;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      next_cycle(); req_i[1] = 1'b1; we_i[1] = 1'b0; addr_i[1] = $urandom; #1;
      checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL err_gnt k%0d: got %b exp 0010", k, gnt_o); end
      next_cycle(); req_i = '0; #1;
      d = $urandom;
      next_cycle(); pready_i = 1'b1; pslverr_i = (k == 0); prdata_i = d; #1;
      next_cycle(); pready_i = 1'b0; pslverr_i = 1'b1; #1;
      checks++; if (rvalid_o !== 4'b0010 || err_o !== (k == 0) || rdata_o !== d) begin
        errors++; $display("FAIL err_resp k%0d: got rv=%b err=%b rdata=%h exp 0010 %b %h", k, rvalid_o, err_o, rdata_o, k == 0, d); end
      pslverr_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle(); req_i[0] = 1'b1; addr_i[0] = $urandom; #1;
    next_cycle(); req_i = '0; #1;
    next_cycle(); pready_i = 1'b0; #1;
    checks++; if (penable_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got pen=%b exp 1", penable_o); end
    rst_i = 1'b1; #1;
    checks++; if ({psel_o, penable_o, rvalid_o} !== '0) begin
      errors++; $display("FAIL rstmid_async: got psel/pen/rv=%b exp 000000", {psel_o, penable_o, rvalid_o}); end
    pready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checks++; if (rvalid_o !== '0) begin errors++; $display("FAIL rstmid_norv: got %b exp 0000", rvalid_o); end
    next_cycle(); pready_i = 1'b0; req_i = 4'b1001; #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rstmid_gnt: got %b exp 0001", gnt_o); end
    next_cycle(); req_i = '0; #1;
    next_cycle(); pready_i = 1'b1; #1;
    next_cycle(); pready_i = 1'b0; #1;
    checks++; if (rvalid_o !== 4'b0001) begin errors++; $display("FAIL rstmid_resp: got %b exp 0001", rvalid_o); end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pen_cnt = 0;
    do_reset();
    next_cycle(); req_i[0] = 1'b1; #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL to_gnt: got %b exp 0001", gnt_o); end
    for (int c = 1; c <= 12; c++) begin
      next_cycle(); req_i = '0; pready_i = 1'b0; prdata_i = $urandom; #1;
      if (penable_o) pen_cnt++;
      if (c == 10) begin
        checks++; if (rvalid_o !== 4'b0001 || err_o !== 1'b1 || rdata_o !== '0) begin
          errors++; $display("FAIL to_resp: got rv=%b err=%b rdata=%h exp 0001 1 0", rvalid_o, err_o, rdata_o); end
      end
    end
    checks++; if (pen_cnt !== TO) begin errors++; $display("FAIL to_len: got %0d exp %0d", pen_cnt, TO); end
    next_cycle(); req_i[0] = 1'b1; #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL to2_gnt: got %b exp 0001", gnt_o); end
    for (int c = 1; c <= 10; c++) begin
      next_cycle(); req_i = '0; pready_i = (c == 9); prdata_i = 32'h1234_5678; #1;
      if (c == 10) begin
        checks++; if (rvalid_o !== 4'b0001 || err_o !== 1'b0 || rdata_o !== 32'h1234_5678) begin
          errors++; $display("FAIL to2_resp: got rv=%b err=%b rdata=%h exp 0001 0 12345678", rvalid_o, err_o, rdata_o); end
      end
    end
    clear_inputs();
  endtask
`endif

  task automatic test_random();
    logic [NB-1:0] pend = '0;
    int            last = NB - 1;
    bit            busy = 1'b0;
    int            tg = 0, w = 0, own = 0, ph = 0;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wd = '0;
    logic [DW-1:0] hold_rd = '0, nxt_rd = '0;
    logic          hold_err = 1'b0, nxt_err = 1'b0;
    logic [NB-1:0] exp_gnt, exp_rv;
    logic          exp_psel, exp_pen;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      next_cycle();
      for (int i = 0; i < NB; i++) begin
        if (!pend[i]) begin
          if (c < 450 && $urandom_range(3) == 0) begin
            pend[i] = 1'b1; req_i[i] = 1'b1; we_i[i] = 1'($urandom);
            addr_i[i] = $urandom; wdata_i[i] = $urandom;
          end else begin
            req_i[i] = 1'b0; addr_i[i] = $urandom; we_i[i] = 1'($urandom);
          end
        end
      end
      ph = c - tg;
      prdata_i = $urandom; pslverr_i = 1'($urandom);
      if (busy && ph == 2 + w) begin
        pready_i = 1'b1; nxt_rd = c_we ? '0 : prdata_i; nxt_err = pslverr_i;
      end else if (busy && ph >= 2 && ph < 2 + w) begin
        pready_i = 1'b0;
      end else begin
        pready_i = 1'($urandom);
      end
      #1;
      exp_rv = '0;
      if (busy && ph == 3 + w) begin
        exp_rv = NB'(1) << own; busy = 1'b0; hold_rd = nxt_rd; hold_err = nxt_err;
      end
      exp_gnt = '0;
      if (!busy && pend != '0) begin
        for (int k = 1; k <= NB; k++) begin
          if (pend[(last + k) % NB]) begin own = (last + k) % NB; break; end
        end
        exp_gnt = NB'(1) << own; last = own; pend[own] = 1'b0;
        busy = 1'b1; tg = c; ph = 0; w = $urandom_range(3);
        c_we = we_i[own]; c_addr = addr_i[own]; c_wd = wdata_i[own];
      end
      exp_psel = busy && ph >= 1 && ph <= 2 + w;
      exp_pen  = busy && ph >= 2 && ph <= 2 + w;
      checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b exp %b", c, gnt_o, exp_gnt); end
      checks++; if (rvalid_o !== exp_rv) begin errors++; $display("FAIL rnd_rvalid c%0d: got %b exp %b", c, rvalid_o, exp_rv); end
      checks++; if (psel_o !== exp_psel || penable_o !== exp_pen) begin
        errors++; $display("FAIL rnd_phase c%0d: got psel=%b pen=%b exp %b %b", c, psel_o, penable_o, exp_psel, exp_pen); end
      checks++; if (rdata_o !== hold_rd || err_o !== hold_err) begin
        errors++; $display("FAIL rnd_resp c%0d: got rdata=%h err=%b exp %h %b", c, rdata_o, err_o, hold_rd, hold_err); end
      if (exp_psel) begin
        checks++; if (paddr_o !== c_addr || pwrite_o !== c_we || pwdata_o !== c_wd) begin
          errors++; $display("FAIL rnd_fields c%0d: got %h %b %h exp %h %b %h", c, paddr_o, pwrite_o, pwdata_o, c_addr, c_we, c_wd); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_wait();
    test_contention();
    test_error();
    test_reset_mid();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
